// File: rtl/ula_operand_loader_pkg.sv
// Shared definitions for the ULA operand loader.
// Holds the FSM state encoding and the default widths.
package ula_operand_loader_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int OPW_DEF   = 3;
   localparam int CNTW_DEF  = 4;

   // 2'd3 is unreachable and decodes to ST_WAIT_A.
   typedef enum logic [1:0] {
      ST_WAIT_A = 2'd0,
      ST_WAIT_B = 2'd1,
      ST_VALID  = 2'd2
   } state_t;

endpackage

// File: rtl/ula_operand_loader_rise_detect.sv
// Rising-edge detector for the load strobe.
// Ports: clk, rst_n (async low), d (level), rise (1-clk pulse).
module ula_operand_loader_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= 1'b0;
      else        d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/ula_operand_loader.sv
// ULA operand loader: captures A, then B + opcode,
// from one shared bus; hands the set out via valid/ready.
// Ports: clk, rst_n (async low), clear_in (sync abort),
//   load_in, data_in, opcode_in -> operand_a, operand_b,
//   opcode, mux_sel, out_valid/out_ready, busy, op_count.
// Option: LOAD_EDGE_EN loads on the rising edge of
//   load_in only; otherwise load_in acts as a level.
module ula_operand_loader
   import ula_operand_loader_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF,
   parameter int CNTW  = CNTW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic [OPW-1:0]   opcode_in,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic [OPW-1:0]   opcode,
   output logic             mux_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNTW-1:0]  op_count
);

   state_t state;
   state_t state_d;
   logic   ld;
   logic   cap_a;
   logic   cap_b;
   logic   hs;

`ifdef LOAD_EDGE_EN
   // Edge history updates every cycle, clear included.
   ula_operand_loader_rise_detect u_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (load_in),
      .rise  (ld)
   );
`else
   assign ld = load_in;
`endif

   always_comb begin
      state_d = ST_WAIT_A;
      cap_a   = 1'b0;
      cap_b   = 1'b0;
      hs      = 1'b0;
      case (state)
         ST_WAIT_A: begin
            if (ld) begin
               cap_a   = 1'b1;
               state_d = ST_WAIT_B;
            end else begin
               state_d = ST_WAIT_A;
            end
         end
         ST_WAIT_B: begin
            if (ld) begin
               cap_b   = 1'b1;
               state_d = ST_VALID;
            end else begin
               state_d = ST_WAIT_B;
            end
         end
         ST_VALID: begin
            // ld is dropped here, even alongside a handshake.
            if (out_ready) begin
               hs      = 1'b1;
               state_d = ST_WAIT_A;
            end else begin
               state_d = ST_VALID;
            end
         end
         default: state_d = ST_WAIT_A;
      endcase
      // Abort wins over loads and the handshake.
      if (clear_in) begin
         state_d = ST_WAIT_A;
         cap_a   = 1'b0;
         cap_b   = 1'b0;
         hs      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_WAIT_A;
         operand_a <= '0;
         operand_b <= '0;
         opcode    <= '0;
         mux_sel   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         op_count  <= '0;
      end else begin
         state     <= state_d;
         // Flags are registered from next state so
         // they line up with the state register.
         out_valid <= (state_d == ST_VALID);
         mux_sel   <= (state_d == ST_VALID);
         busy      <= (state_d != ST_WAIT_A);
         if (cap_a) operand_a <= data_in;
         if (cap_b) begin
            operand_b <= data_in;
            opcode    <= opcode_in;
         end
         if (hs) op_count <= op_count + CNTW'(1);
      end
   end

endmodule
